// File: rtl/axi_stream_frame_ring_writer.sv
// AXI-stream video frame writer into a ring of NUM_BUFS frame buffers.
// Each frame is written as fixed-length AXI bursts. The base address of every
// completed frame is published to downstream readers. The stream is held off
// while every buffer is still owned by a consumer.
//
// state  | meaning
// IDLE   | drop stray beats, wait for a start-of-frame beat and a free buffer
// ADDR   | present the burst address, wait for awready
// DATA   | stream beats pass straight through to the W channel
// RESP   | wait for the burst write response
// DONE   | publish the frame, advance the ring pointer
module axi_stream_frame_ring_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BUFS   = 4,
    parameter int BURST_LEN  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] BUF_STRIDE = 32'h0010_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 pixels_per_frame,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tuser,
    output logic [ADDR_WIDTH-1:0]       awaddr,
    output logic [7:0]                  awlen,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [DATA_WIDTH-1:0]       wdata,
    output logic                        wvalid,
    input  logic                        wready,
    output logic                        wlast,
    input  logic                        bvalid,
    output logic                        bready,
    output logic                        frame_ready,
    output logic [ADDR_WIDTH-1:0]       frame_base_addr,
    input  logic                        frame_release,
    output logic [$clog2(NUM_BUFS):0]   bufs_used,
    output logic                        frame_error
);

    localparam int PTR_W = $clog2(NUM_BUFS);
    localparam int CNT_W = PTR_W + 1;
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [PTR_W-1:0]        wr_ptr;
    logic [31:0]             frame_len;
    logic [31:0]             beat_cnt;
    logic [7:0]              burst_cnt;
    logic [ADDR_WIDTH-1:0]   buf_base;
    logic                    full;
    logic                    beat_xfer;
    logic                    burst_end;
    logic                    frame_last_beat;
    logic                    frame_complete;
    logic                    bufs_inc;
    logic                    bufs_dec;

    assign awlen           = 8'(BURST_LEN - 1);
    assign full            = (bufs_used == CNT_W'(NUM_BUFS));
    assign beat_xfer       = (state == S_DATA) && s_axis_tvalid && wready;
    assign burst_end       = (burst_cnt == 8'(BURST_LEN - 1));
    assign frame_last_beat = (beat_cnt == frame_len - 32'd1);
    assign frame_complete  = (beat_cnt == frame_len);
    assign buf_base        = BASE_ADDR + ADDR_WIDTH'(wr_ptr) * BUF_STRIDE;
    assign bufs_inc        = (state == S_DONE);
    assign bufs_dec        = frame_release && (bufs_used != '0);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (!full && s_axis_tvalid && s_axis_tuser) state_nxt = S_ADDR;
            S_ADDR: if (awready) state_nxt = S_DATA;
            S_DATA: if (beat_xfer && burst_end) state_nxt = S_RESP;
            S_RESP: if (bvalid) state_nxt = frame_complete ? S_DONE : S_ADDR;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; the start-of-frame beat is held in IDLE so it gets written.
    always_comb begin
        s_axis_tready = 1'b0;
        awvalid       = 1'b0;
        awaddr        = '0;
        wvalid        = 1'b0;
        wdata         = '0;
        wlast         = 1'b0;
        bready        = 1'b0;
        frame_ready   = 1'b0;
        case (state)
            S_IDLE: s_axis_tready = s_axis_tvalid && !s_axis_tuser && !full;
            S_ADDR: begin
                awvalid = 1'b1;
                awaddr  = buf_base + ADDR_WIDTH'(beat_cnt) * ADDR_WIDTH'(BYTES);
            end
            S_DATA: begin
                wvalid        = s_axis_tvalid;
                wdata         = s_axis_tdata;
                wlast         = burst_end;
                s_axis_tready = wready;
            end
            S_RESP: bready = 1'b1;
            S_DONE: frame_ready = 1'b1;
            default: ;
        endcase
    end

    // Frame counters, ring pointer, occupancy and marker checking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            frame_len       <= '0;
            beat_cnt        <= '0;
            burst_cnt       <= '0;
            frame_base_addr <= '0;
            bufs_used       <= '0;
            frame_error     <= 1'b0;
        end else begin
            frame_error <= beat_xfer &&
                           ((s_axis_tlast != frame_last_beat) ||
                            (s_axis_tuser && (beat_cnt != 32'd0)));
            if (state == S_IDLE && state_nxt == S_ADDR) begin
                frame_len <= pixels_per_frame;
                beat_cnt  <= '0;
                burst_cnt <= '0;
            end
            if (beat_xfer) begin
                beat_cnt  <= beat_cnt + 32'd1;
                burst_cnt <= burst_end ? 8'd0 : burst_cnt + 8'd1;
            end
            if (state == S_RESP && bvalid && frame_complete)
                frame_base_addr <= buf_base;
            if (state == S_DONE)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (bufs_inc && !bufs_dec)
                bufs_used <= bufs_used + CNT_W'(1);
            else if (!bufs_inc && bufs_dec)
                bufs_used <= bufs_used - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axi_stream_frame_ring_writer.sv
// Bench for the frame ring writer: table of frame scenarios, hand-written
// corner sequences and randomized frames, checked against a memory-level model.
module tb_axi_stream_frame_ring_writer;

    localparam int BL = 4;
    localparam int NB = 4;
    localparam logic [31:0] STRIDE = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pixels_per_frame;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic        wvalid, wready, wlast;
    logic        bvalid, bready;
    logic        frame_ready;
    logic [31:0] frame_base_addr;
    logic        frame_release;
    logic [2:0]  bufs_used;
    logic        frame_error;

    axi_stream_frame_ring_writer #(.BURST_LEN(BL), .NUM_BUFS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .pixels_per_frame(pixels_per_frame),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .awaddr(awaddr), .awlen(awlen),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wvalid(wvalid),
        .wready(wready), .wlast(wlast), .bvalid(bvalid), .bready(bready),
        .frame_ready(frame_ready), .frame_base_addr(frame_base_addr),
        .frame_release(frame_release), .bufs_used(bufs_used),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stall_pct = 0;
    int proto_err = 0;
    int w_beats = 0;
    int ready_cnt = 0;
    int err_cnt = 0;
    int frames_done = 0;
    int exp_bufs = 0;
    bit release_on_done = 0;
    logic [31:0] last_base = '0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] aw_log[$];
    logic [31:0] fdata[$];

    typedef struct {
        int ppf;
        int junk;
        int bad_last;
        bit drop_last;
        int extra_user;
        int stall;
        int gap;
        int exp_err;
        int exp_bufs_after;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory slave with random ready/response stalls; also polices AXI rules.
    initial begin
        logic [31:0] cur, aw_prev;
        int beat;
        bit bp, btake, aw_hold;
        awready = 0; wready = 0; bvalid = 0;
        cur = 0; aw_prev = 0; beat = 0; bp = 0; aw_hold = 0;
        forever begin
            @(negedge clk);
            btake = 0;
            if (!rst_n) begin
                bp = 0; beat = 0; aw_hold = 0;
            end else begin
                if (aw_hold && awvalid && awaddr !== aw_prev) proto_err++;
                aw_hold = awvalid && !awready;
                aw_prev = awaddr;
                if (awvalid && awready) begin
                    cur = awaddr; beat = 0;
                    aw_log.push_back(awaddr);
                    if (awlen !== 8'(BL - 1)) proto_err++;
                end
                if (wvalid && wready) begin
                    mem[cur + 32'(beat * 4)] = wdata;
                    if (wlast !== (beat == BL - 1)) proto_err++;
                    beat++;
                    w_beats++;
                    if (wlast) bp = 1;
                end
                btake = bvalid && bready;
            end
            @(posedge clk); #1;
            if (btake) bp = 0;
            awready = ($urandom_range(99) >= stall_pct);
            wready  = ($urandom_range(99) >= stall_pct);
            bvalid  = bp && (bvalid || ($urandom_range(99) >= stall_pct));
        end
    end

    // Frame publication monitor; optionally releases a buffer in the DONE cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && frame_error) err_cnt++;
            if (rst_n && frame_ready) begin
                ready_cnt++;
                last_base = frame_base_addr;
                if (release_on_done) begin
                    release_on_done = 0;
                    frame_release = 1;
                    @(posedge clk); #1;
                    frame_release = 0;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_beat(input logic [31:0] d, input logic u, input logic l, input int gap);
        int n;
        if (gap > 0) begin
            s_axis_tvalid = 0;
            repeat (gap) @(posedge clk);
            #1;
        end
        s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            n++;
            if (n > 5000) begin
                checks++; errors++;
                $display("FAIL stream handshake: got no tready expected tready within 5000 cycles");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic release_one();
        @(posedge clk); #1;
        frame_release = 1;
        @(posedge clk); #1;
        frame_release = 0;
        if (exp_bufs > 0) exp_bufs--;
    endtask

    task automatic send_frame(input int ppf, input int junk, input int bad_last, input bit drop_last,
                              input int extra_user, input int gap_pct, input int exp_err,
                              input bit rel_in_done);
        int r0, e0, w0, n, nbad, gap;
        logic [31:0] base, a;
        pixels_per_frame = ppf;
        fdata.delete();
        aw_log.delete();
        r0 = ready_cnt; e0 = err_cnt; w0 = w_beats;
        release_on_done = rel_in_done;
        for (int j = 0; j < junk; j++) push_beat($urandom, 1'b0, 1'b0, 0);
        for (int i = 0; i < ppf; i++) fdata.push_back($urandom);
        for (int i = 0; i < ppf; i++) begin
            gap = ($urandom_range(99) < gap_pct) ? $urandom_range(3, 1) : 0;
            push_beat(fdata[i], (i == 0) || (i == extra_user),
                      ((i == ppf - 1) && !drop_last) || (i == bad_last), gap);
            if (i == 0) pixels_per_frame = $urandom_range(1, 8) * BL;
        end
        s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
        n = 0;
        while (ready_cnt == r0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        base = 32'(frames_done % NB) * STRIDE;
        frames_done++;
        if (!rel_in_done) exp_bufs++;
        chk("frame_ready pulses", 64'(ready_cnt - r0), 1);
        chk("frame_base_addr", last_base, base);
        chk("frame_error pulses", 64'(err_cnt - e0), 64'(exp_err));
        chk("bufs_used", bufs_used, 64'(exp_bufs));
        chk("written beats", 64'(w_beats - w0), 64'(ppf));
        nbad = 0;
        for (int i = 0; i < ppf; i++) begin
            a = base + 32'(i * 4);
            if (!mem.exists(a)) nbad++;
            else if (mem[a] !== fdata[i]) nbad++;
        end
        chk("memory image mismatches", 64'(nbad), 0);
        nbad = 0;
        if (aw_log.size() != ppf / BL) nbad = 1000 + aw_log.size();
        else
            for (int b = 0; b < ppf / BL; b++)
                if (aw_log[b] !== base + 32'(b * BL * 4)) nbad++;
        chk("burst address errors", 64'(nbad), 0);
    endtask

    initial begin
        vec_t vecs[4];
        int n_rdy, n_aw, nppf;
        logic [31:0] base;

        vecs[0] = '{ppf:16, junk:0, bad_last:-1, drop_last:0, extra_user:-1, stall:0,  gap:0,  exp_err:0, exp_bufs_after:1};
        vecs[1] = '{ppf:16, junk:3, bad_last:-1, drop_last:0, extra_user:-1, stall:0,  gap:0,  exp_err:0, exp_bufs_after:2};
        vecs[2] = '{ppf:16, junk:0, bad_last:7,  drop_last:0, extra_user:-1, stall:30, gap:30, exp_err:1, exp_bufs_after:3};
        vecs[3] = '{ppf:16, junk:0, bad_last:-1, drop_last:1, extra_user:5,  stall:50, gap:50, exp_err:2, exp_bufs_after:4};

        rst_n = 0; pixels_per_frame = 0; s_axis_tdata = 0; s_axis_tvalid = 0;
        s_axis_tlast = 0; s_axis_tuser = 0; frame_release = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset control outputs",
            {awvalid, wvalid, wlast, bready, s_axis_tready, frame_ready, frame_error, bufs_used}, 0);
        chk("reset address outputs", {awaddr, frame_base_addr}, 0);
        chk("reset awlen", awlen, 64'(BL - 1));
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // Four frames into an empty ring, no releases.
        for (int v = 0; v < 4; v++) begin
            stall_pct = vecs[v].stall;
            send_frame(vecs[v].ppf, vecs[v].junk, vecs[v].bad_last, vecs[v].drop_last,
                       vecs[v].extra_user, vecs[v].gap, vecs[v].exp_err, 0);
            chk("table bufs_used", bufs_used, 64'(vecs[v].exp_bufs_after));
        end

        // Ring full: a new start-of-frame beat must be held off.
        stall_pct = 0;
        s_axis_tdata = 32'h5555_0000; s_axis_tuser = 1; s_axis_tvalid = 1;
        n_rdy = 0; n_aw = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_axis_tready) n_rdy++;
            if (awvalid) n_aw++;
        end
        chk("full ring tready cycles", 64'(n_rdy), 0);
        chk("full ring awvalid cycles", 64'(n_aw), 0);
        @(posedge clk); #1;
        s_axis_tvalid = 0; s_axis_tuser = 0;
        release_one();
        send_frame(16, 0, -1, 0, -1, 0, 0, 0);

        // Release coinciding with DONE leaves occupancy unchanged.
        release_one();
        release_one();
        chk("bufs_used after releases", bufs_used, 64'(exp_bufs));
        send_frame(16, 0, -1, 0, -1, 20, 0, 1);

        // Randomized stalls, gaps and frame lengths.
        for (int k = 0; k < 6; k++) begin
            stall_pct = $urandom_range(10, 60);
            nppf = $urandom_range(1, 6) * BL;
            release_one();
            send_frame(nppf, $urandom_range(0, 2), -1, 0, -1, 40, 0, 0);
        end

        // Address latency, then reset in the middle of a burst.
        stall_pct = 0;
        base = 32'(frames_done % NB) * STRIDE;
        pixels_per_frame = 16;
        s_axis_tdata = 32'hAAAA_0000; s_axis_tuser = 1; s_axis_tlast = 0; s_axis_tvalid = 1;
        @(negedge clk);
        chk("tuser beat held in idle", {s_axis_tready, awvalid}, 0);
        @(negedge clk);
        chk("first awvalid/awaddr", {awvalid, awaddr}, {1'b1, base});
        @(posedge clk); #1;
        push_beat(32'hAAAA_0000, 1'b1, 1'b0, 0);
        push_beat(32'hAAAA_0001, 1'b0, 1'b0, 0);
        rst_n = 0; s_axis_tvalid = 0; s_axis_tuser = 0;
        #1;
        chk("async reset control outputs",
            {awvalid, wvalid, wlast, bready, s_axis_tready, frame_ready, frame_error, bufs_used}, 0);
        chk("async reset address outputs", {awaddr, frame_base_addr, wdata}, 0);
        exp_bufs = 0;
        frames_done = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(16, 0, -1, 0, -1, 20, 0, 0);

        chk("AXI protocol violations", 64'(proto_err), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
